if_prefetch_queue: RTL



---
 rtl/if_prefetch_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: owns the fetch PC, issues req/ack reads to a
// variable-latency instruction memory and buffers {pc, instr} pairs for IF/ID.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     stall,
    output logic                     instr_valid,
    output logic [31:0]              PC_Out,
    output logic [31:0]              Instr,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e        state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_addr_q;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          not_empty;
    logic          push;
    logic          pop;
    logic          has_space;
    logic [31:0]   next_pc;

    assign not_empty   = (count_q != '0);
    assign instr_valid = not_empty && !redirect;
    assign pop         = instr_valid && !stall;
    assign push        = (state_q == StReq) && imem_ack && !redirect;
    assign next_pc     = fetch_pc_q + PC_STEP;

    always_comb begin
        count_next = count_q;
        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count_q + CW'(push) - CW'(pop);
        end
    end

    // A slot is reserved whenever a request is issued, so pushes never overflow.
    assign has_space = (count_next < FULL);

    assign imem_req  = (state_q != StIdle);
    assign imem_addr = req_addr_q;
    assign PC_Out    = not_empty ? pc_mem[rd_ptr_q]  : 32'h0;
    assign Instr     = not_empty ? ins_mem[rd_ptr_q] : 32'h0;
    assign occupancy = count_q;

    always_ff @(posedge clk) begin
        if (rst && push) begin
            pc_mem[wr_ptr_q]  <= fetch_pc_q;
            ins_mem[wr_ptr_q] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            count_q <= count_next;
            if (redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                        req_addr_q <= redirect_pc;
                        state_q    <= StReq;
                    end else if (has_space) begin
                        req_addr_q <= fetch_pc_q;
                        state_q    <= StReq;
                    end
                end
                StReq: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                        if (imem_ack) begin
                            req_addr_q <= redirect_pc;
                            state_q    <= StReq;
                        end else begin
                            // Outstanding request keeps its address until its ack drains.
                            state_q <= StDiscard;
                        end
                    end else if (imem_ack) begin
                        fetch_pc_q <= next_pc;
                        req_addr_q <= next_pc;
                        state_q    <= has_space ? StReq : StIdle;
                    end
                end
                StDiscard: begin
                    if (redirect) fetch_pc_q <= redirect_pc;
                    // A redirect coinciding with the stale ack must not wait for another ack.
                    if (imem_ack) begin
                        req_addr_q <= redirect ? redirect_pc : fetch_pc_q;
                        state_q    <= has_space ? StReq : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
